register_file: RTL and testbench

Parametrised successor to the 8×8 register bank: a DEPTH×WIDTH register file with two registered read ports and one write port, all usable in the same cycle. It adds same-cycle write-to-read forwarding, an optional hardwired-zero register 0, and a multi-cycle background clear sequencer with a busy flag. It sits in the DiBU datapath between decode (register indices) and the ALU (operands a/b).

---
 rtl/register_file_if.sv | 26 ++
 rtl/register_file.sv | 98 +++++++++
 tb/tb_register_file.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Operand-port bundle between decode/writeback (master) and the register file (slave).
// Carries read/write indices, write data, clear request and the registered results.
interface register_file_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] ri_a;
    logic [ADDR_W-1:0] ri_b;
    logic [ADDR_W-1:0] ri_d;
    logic              we;
    logic [WIDTH-1:0]  d;
    logic              clr;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              busy;

    modport master (
        output ri_a, ri_b, ri_d, we, d, clr,
        input  a, b, busy
    );

    modport slave (
        input  ri_a, ri_b, ri_d, we, d, clr,
        output a, b, busy
    );
endinterface

// File: rtl/register_file.sv
// DEPTH x WIDTH register file: two registered read ports, one write port with
// same-cycle forwarding, optional hardwired-zero r0 and a background clear sweep.
//
// state | meaning
// IDLE  | normal operation, writes accepted, clr starts a sweep
// SWEEP | clearing bank[cnt] each cycle, writes and clr ignored, busy high
module register_file #(
    parameter int WIDTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 0
) (
    input  logic           clk,
    input  logic           rst,
    register_file_if.slave bus
);
    localparam int                DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
    localparam bit                ZERO  = (ZERO_R0 != 0);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t            state_q;
    logic              busy_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [WIDTH-1:0]  bank_q [DEPTH];
    logic [WIDTH-1:0]  a_q, b_q;
    logic [WIDTH-1:0]  a_d, b_d;
    logic              wr_ok;
    logic              sweeping;

    // Value a read port captures at this edge: post-write, post-clear view of the array.
    function automatic logic [WIDTH-1:0] read_port(
        input logic [ADDR_W-1:0] idx,
        input logic [WIDTH-1:0]  stored,
        input logic              fwd_en,
        input logic [ADDR_W-1:0] fwd_idx,
        input logic [WIDTH-1:0]  fwd_data,
        input logic              clr_en,
        input logic [ADDR_W-1:0] clr_idx
    );
        logic [WIDTH-1:0] val;
        val = stored;
        if (clr_en && idx == clr_idx) val = '0;
        if (fwd_en && idx == fwd_idx) val = fwd_data;
        if (ZERO && idx == '0)        val = '0;
        return val;
    endfunction

    always_comb begin
        sweeping = (state_q == SWEEP);
        wr_ok    = bus.we && !sweeping && !(ZERO && bus.ri_d == '0);
        a_d      = read_port(bus.ri_a, bank_q[bus.ri_a], wr_ok, bus.ri_d, bus.d, sweeping, cnt_q);
        b_d      = read_port(bus.ri_b, bank_q[bus.ri_b], wr_ok, bus.ri_d, bus.d, sweeping, cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            if (wr_ok) bank_q[bus.ri_d] <= bus.d;
            case (state_q)
                IDLE: begin
                    if (bus.clr) begin
                        state_q <= SWEEP;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                SWEEP: begin
                    bank_q[cnt_q] <= '0;
                    cnt_q         <= cnt_q + ADDR_W'(1);
                    if (cnt_q == LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a    = a_q;
    assign bus.b    = b_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: three configurations (8x8, 8x8 with zero r0, 16x16)
// driven side by side and scored against an array model of the register contents.
module tb_register_file;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    register_file_if #(.WIDTH(8),  .ADDR_W(3)) if0 ();
    register_file_if #(.WIDTH(8),  .ADDR_W(3)) if1 ();
    register_file_if #(.WIDTH(16), .ADDR_W(4)) if2 ();

    register_file #(.WIDTH(8),  .ADDR_W(3), .ZERO_R0(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    register_file #(.WIDTH(8),  .ADDR_W(3), .ZERO_R0(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    register_file #(.WIDTH(16), .ADDR_W(4), .ZERO_R0(0)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    logic        s_rst;
    logic [3:0]  s_ra  [3];
    logic [3:0]  s_rb  [3];
    logic [3:0]  s_rd  [3];
    logic [15:0] s_d   [3];
    logic        s_we  [3];
    logic        s_clr [3];

    assign rst = s_rst;
    assign if0.ri_a = s_ra[0][2:0];
    assign if0.ri_b = s_rb[0][2:0];
    assign if0.ri_d = s_rd[0][2:0];
    assign if0.we   = s_we[0];
    assign if0.d    = s_d[0][7:0];
    assign if0.clr  = s_clr[0];
    assign if1.ri_a = s_ra[1][2:0];
    assign if1.ri_b = s_rb[1][2:0];
    assign if1.ri_d = s_rd[1][2:0];
    assign if1.we   = s_we[1];
    assign if1.d    = s_d[1][7:0];
    assign if1.clr  = s_clr[1];
    assign if2.ri_a = s_ra[2];
    assign if2.ri_b = s_rb[2];
    assign if2.ri_d = s_rd[2];
    assign if2.we   = s_we[2];
    assign if2.d    = s_d[2];
    assign if2.clr  = s_clr[2];

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        busy;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int vectors    = 0;
    int miscompares = 0;
    int cycle      = 0;

    // Reference state: register contents, and how many entries of a running sweep are done (-1 = none running)
    int mem   [3][16];
    int swept [3];

    function automatic int dep(input int c);
        return (c == 2) ? 16 : 8;
    endfunction

    function automatic int dmask(input int c);
        return (c == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
    endfunction

    // Registered outputs show the array as it stands right after the edge.
    task automatic model_edge(input int c);
        int   rd;
        exp_t e;
        rd = int'(s_rd[c]);
        if (s_rst) begin
            for (int i = 0; i < 16; i++) mem[c][i] = 0;
            swept[c] = -1;
        end else if (swept[c] >= 0) begin
            mem[c][swept[c]] = 0;
            swept[c] = swept[c] + 1;
            if (swept[c] == dep(c)) swept[c] = -1;
        end else begin
            if (s_we[c] && !(c == 1 && rd == 0)) mem[c][rd] = int'(s_d[c]) & dmask(c);
            if (s_clr[c]) swept[c] = 0;
        end
        e.a    = 16'(mem[c][int'(s_ra[c])]);
        e.b    = 16'(mem[c][int'(s_rb[c])]);
        e.busy = (swept[c] >= 0);
        case (c)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        model_edge(2);
        cycle++;
        #1;
    endtask

    task automatic set_all(input int ra, input int rb, input int rd, input bit we, input int d, input bit clr);
        for (int c = 0; c < 3; c++) begin
            s_ra[c]  = 4'(ra & (dep(c) - 1));
            s_rb[c]  = 4'(rb & (dep(c) - 1));
            s_rd[c]  = 4'(rd & (dep(c) - 1));
            s_we[c]  = we;
            s_d[c]   = 16'(d);
            s_clr[c] = clr;
        end
    endtask

    task automatic randomize_inputs();
        for (int c = 0; c < 3; c++) begin
            s_ra[c]  = 4'($urandom_range(0, dep(c) - 1));
            s_rb[c]  = 4'($urandom_range(0, dep(c) - 1));
            s_rd[c]  = 4'($urandom_range(0, dep(c) - 1));
            s_we[c]  = 1'($urandom_range(0, 1));
            s_d[c]   = 16'($urandom);
            s_clr[c] = ($urandom_range(0, 15) == 0);
        end
        s_rst = ($urandom_range(0, 199) == 0);
    endtask

    function automatic exp_t dut_out(input int c);
        exp_t g;
        case (c)
            0:       begin g.a = 16'(if0.a); g.b = 16'(if0.b); g.busy = if0.busy; end
            1:       begin g.a = 16'(if1.a); g.b = 16'(if1.b); g.busy = if1.busy; end
            default: begin g.a = if2.a;      g.b = if2.b;      g.busy = if2.busy; end
        endcase
        return g;
    endfunction

    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            exp_t e;
            exp_t g;
            bit   have;
            have = 1'b0;
            case (c)
                0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            if (have) begin
                g = dut_out(c);
                vectors++;
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL cfg%0d cycle %0d: got a=%h b=%h busy=%b, expected a=%h b=%h busy=%b",
                             c, cycle, g.a, g.b, g.busy, e.a, e.b, e.busy);
                end
            end
        end
    end

    initial begin
        for (int c = 0; c < 3; c++) swept[c] = -1;
        s_rst = 1'b1;
        set_all(0, 0, 0, 1'b0, 0, 1'b0);
        tick();
        tick();
        s_rst = 1'b0;

        // write then read back, and an untouched index
        set_all(0, 0, 3, 1'b1, 'h5A, 1'b0); tick();
        set_all(3, 3, 0, 1'b0, 0, 1'b0);    tick();
        set_all(4, 3, 0, 1'b0, 0, 1'b0);    tick();

        // forwarding on port a while port b reads the array
        set_all(0, 0, 5, 1'b1, 'h11, 1'b0); tick();
        set_all(2, 5, 2, 1'b1, 'hC3, 1'b0); tick();
        set_all(2, 5, 0, 1'b0, 0, 1'b0);    tick();
        set_all(2, 2, 2, 1'b1, 'h3C, 1'b0); tick();

        // write to index 0 (dropped only in the zero-r0 instance)
        set_all(0, 1, 0, 1'b1, 'hFF, 1'b0); tick();
        set_all(0, 0, 0, 1'b0, 0, 1'b0);    tick();

        // fill, then sweep with writes and clr attempts during it
        for (int i = 0; i < 8; i++) begin
            set_all(i, 0, i, 1'b1, 'h10 + i, 1'b0); tick();
        end
        for (int i = 8; i < 16; i++) begin
            set_all(0, 0, 0, 1'b0, 0, 1'b0);
            s_rd[2] = 4'(i); s_we[2] = 1'b1; s_d[2] = 16'('h10 + i);
            tick();
        end
        set_all(7, 0, 0, 1'b0, 0, 1'b1); tick();
        for (int k = 0; k < 8; k++) begin
            set_all(7, k, 7, 1'b1, 'hEE, 1'b1); tick();
        end
        for (int k = 0; k < 10; k++) begin
            set_all(7, 15 - k, 0, 1'b0, 0, 1'b0); tick();
        end
        for (int i = 0; i < 16; i++) begin
            set_all(i, 15 - i, 0, 1'b0, 0, 1'b0); tick();
        end

        // clr and write in the same idle cycle, then reset in the middle of a sweep
        set_all(6, 6, 6, 1'b1, 'h77, 1'b1); tick();
        for (int k = 0; k < 17; k++) begin
            set_all(6, k, 0, 1'b0, 0, 1'b0); tick();
        end
        for (int i = 0; i < 8; i++) begin
            set_all(i, i, i, 1'b1, 'h20 + i, 1'b0); tick();
        end
        set_all(1, 2, 0, 1'b0, 0, 1'b1); tick();
        for (int k = 0; k < 4; k++) begin
            set_all(5, 6, 0, 1'b0, 0, 1'b0); tick();
        end
        s_rst = 1'b1; set_all(5, 6, 3, 1'b1, 'h99, 1'b1); tick();
        s_rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_all(i, 15 - i, 0, 1'b0, 0, 1'b0); tick();
        end
        set_all(0, 0, 0, 1'b0, 0, 1'b1); tick();
        for (int k = 0; k < 18; k++) begin
            set_all(k, 0, 0, 1'b0, 0, 1'b0); tick();
        end

        // wide configuration, top index
        set_all(0, 0, 0, 1'b0, 0, 1'b0);
        s_rd[2] = 4'd15; s_we[2] = 1'b1; s_d[2] = 16'hBEEF;
        tick();
        set_all(15, 15, 0, 1'b0, 0, 1'b0); tick();
        tick();

        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            tick();
        end
        s_rst = 1'b0;
        set_all(0, 0, 0, 1'b0, 0, 1'b0);
        for (int k = 0; k < 20; k++) tick();

        @(negedge clk);
        #1;
        vectors++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses never compared, required 0",
                     q0.size() + q1.size() + q2.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
